regfile_wb_arbiter: RTL and testbench

//   Owns the single write port of the 32x32 register bank and shares it between three writeback

---
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the 32x32 register bank and shares it among
//   three writeback requesters: memory load (mem), jal link (link, always r31)
//   and ALU result (alu). After reset it sweeps zeros into every register so
//   the bank needs no bulk reset. It also exports a pending-write mask for
//   read-after-write stall detection in decode.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   mem_valid/addr/data        load writeback request      -> mem_ready
//   link_valid/link_data       jal link request (r31)      -> link_ready
//   alu_valid/addr/data        ALU writeback request       -> alu_ready
//   rf_we/rf_waddr/rf_wdata    registered bank write port
//   init_done                  clear sweep complete, arbiter in RUN
//   pending_mask               bit r = write to register r in flight
module regfile_wb_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int STARVE_LIMIT   = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              link_valid,
  input  logic [DATA_W-1:0] link_data,
  output logic              link_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done,
  output logic [31:0]       pending_mask
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [3:0]        wait_cnt [3];
  logic [2:0]        req;
  logic [2:0]        starved;
  logic [2:0]        grant;
  logic [31:0]       pm;

  // Requester index order: mem=0, link=1, alu=2.
  always_comb begin
    req = {alu_valid, link_valid, mem_valid};
    starved = '0;
    for (int i = 0; i < 3; i++) begin
      starved[i] = req[i] && (wait_cnt[i] == LIMIT);
    end
  end

  // A starved requester overrides fixed priority; among several starved ones
  // the lowest index wins. Nothing is granted outside RUN or during reset.
  always_comb begin
    grant = '0;
    if (state == RUN && !reset) begin
      if      (starved[0]) grant = 3'b001;
      else if (starved[1]) grant = 3'b010;
      else if (starved[2]) grant = 3'b100;
      else if (req[0])     grant = 3'b001;
      else if (req[1])     grant = 3'b010;
      else if (req[2])     grant = 3'b100;
    end
  end

  assign mem_ready  = grant[0];
  assign link_ready = grant[1];
  assign alu_ready  = grant[2];

  // During the sweep every register is effectively in flight, so decode must
  // stall on everything. r0 is never reported pending in RUN.
  always_comb begin
    pm = '0;
    if (reset || state == CLEAR) begin
      pm = '1;
    end else begin
      if (mem_valid)  pm[mem_addr] = 1'b1;
      if (link_valid) pm[{ADDR_W{1'b1}}] = 1'b1;
      if (alu_valid)  pm[alu_addr] = 1'b1;
      if (rf_we)      pm[rf_waddr] = 1'b1;
      pm[0] = 1'b0;
    end
  end

  assign pending_mask = pm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt   <= '0;
      for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= clr_cnt;
          rf_wdata <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_W{1'b1}}) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          for (int i = 0; i < 3; i++) begin
            if (req[i] && !grant[i])
              wait_cnt[i] <= (wait_cnt[i] == LIMIT) ? wait_cnt[i] : wait_cnt[i] + 4'd1;
            else
              wait_cnt[i] <= '0;
          end
          // Writes to r0 are accepted but dropped at the write enable.
          if (grant[0]) begin
            rf_we    <= (mem_addr != '0);
            rf_waddr <= mem_addr;
            rf_wdata <= mem_data;
          end else if (grant[1]) begin
            rf_we    <= 1'b1;
            rf_waddr <= {ADDR_W{1'b1}};
            rf_wdata <= link_data;
          end else if (grant[2]) begin
            rf_we    <= (alu_addr != '0);
            rf_waddr <= alu_addr;
            rf_wdata <= alu_data;
          end else begin
            rf_we    <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid, link_valid, alu_valid;
  logic [4:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, link_data, alu_data;
  logic        mem_ready, link_ready, alu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;
  logic [31:0] pending_mask;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_done(init_done), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [4:0]  a;
    logic [31:0] d;
    bit          init;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one expected write-port state per clock edge.
  initial begin : model
    int          wt[3];
    bit          in_clear;
    int          clr_i;
    int          g;
    exp_t        cur;
    bit   [2:0]  v;
    logic [4:0]  ta[3];
    logic [31:0] td[3];
    logic [31:0] pm;
    logic [2:0]  rdy;
    in_clear = 1;
    clr_i = 0;
    for (int i = 0; i < 3; i++) wt[i] = 0;
    cur = '{we: 0, a: 0, d: 0, init: 0};
    forever begin
      @(negedge clk);
      v  = {alu_valid, link_valid, mem_valid};
      ta = '{mem_addr, 5'd31, alu_addr};
      td = '{mem_data, link_data, alu_data};
      g  = -1;
      if (reset || in_clear) begin
        check("ready_idle", {alu_ready, link_ready, mem_ready}, 3'b000);
        check("pending_clear", pending_mask, 32'hFFFF_FFFF);
      end else begin
        for (int i = 0; i < 3; i++) if (g < 0 && v[i] && wt[i] == LIMIT) g = i;
        for (int i = 0; i < 3; i++) if (g < 0 && v[i]) g = i;
        rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        check("ready", {alu_ready, link_ready, mem_ready}, rdy);
        pm = '0;
        for (int i = 0; i < 3; i++) if (v[i]) pm[ta[i]] = 1'b1;
        if (cur.we) pm[cur.a] = 1'b1;
        pm[0] = 1'b0;
        check("pending", pending_mask, pm);
      end
      @(posedge clk);
      if (reset) begin
        in_clear = 1;
        clr_i = 0;
        for (int i = 0; i < 3; i++) wt[i] = 0;
        cur = '{we: 0, a: 0, d: 0, init: 0};
      end else if (in_clear) begin
        if (clr_i == 31) begin
          in_clear = 0;
          cur.init = 1;
        end
        cur.we = 1;
        cur.a  = 5'(clr_i);
        cur.d  = 0;
        clr_i++;
      end else begin
        for (int i = 0; i < 3; i++)
          wt[i] = (v[i] && g != i) ? ((wt[i] + 1 > LIMIT) ? LIMIT : wt[i] + 1) : 0;
        if (g >= 0) begin
          cur.we = (ta[g] != 0);
          cur.a  = ta[g];
          cur.d  = td[g];
        end else begin
          cur.we = 0;
        end
      end
      exp_q.push_back(cur);
    end
  end

  // Monitor: compares the registered write port against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_we", rf_we, e.we);
        check("rf_waddr", rf_waddr, e.a);
        check("rf_wdata", rf_wdata, e.d);
        check("init_done", init_done, e.init);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Requester state; each request holds until accepted.
  bit          rv[3];
  logic [4:0]  ra[3];
  logic [31:0] rd[3];

  task automatic drive();
    mem_valid  = rv[0]; mem_addr = ra[0]; mem_data = rd[0];
    link_valid = rv[1]; link_data = rd[1];
    alu_valid  = rv[2]; alu_addr = ra[2]; alu_data = rd[2];
  endtask

  task automatic step();
    bit [2:0] acc;
    @(negedge clk);
    acc = {alu_ready & alu_valid, link_ready & link_valid, mem_ready & mem_valid};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i]) rv[i] = 0;
    drive();
  endtask

  task automatic issue(input int i, input logic [4:0] a, input logic [31:0] d);
    rv[i] = 1;
    ra[i] = (i == 1) ? 5'd31 : a;
    rd[i] = d;
    drive();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((rv[0] | rv[1] | rv[2]) && n < max) begin
      step();
      n++;
    end
    check("drain_bound", {rv[2], rv[1], rv[0]}, 3'b000);
  endtask

  task automatic wait_init(input int max);
    int n = 0;
    while (!init_done && n < max) begin
      step();
      n++;
    end
    check("init_bound", init_done, 1'b1);
  endtask

  task automatic random_issue(input int pct);
    for (int i = 0; i < 3; i++)
      if (!rv[i] && $urandom_range(0, 99) < pct)
        issue(i, 5'($urandom_range(0, 31)), $urandom);
  endtask

  initial begin : stim
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; ra[i] = 0; rd[i] = 0;
    end
    drive();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Abort the sweep partway through, then let it run to completion.
    repeat (10) step();
    reset = 1;
    step();
    reset = 0;
    wait_init(40);
    step();

    // Three simultaneous requests.
    issue(0, 5'd5, 32'h0000_AAAA);
    issue(1, 5'd31, 32'h0040_0008);
    issue(2, 5'd7, 32'h0000_1234);
    wait_idle(10);
    step();

    // Write to r0 is accepted and dropped.
    issue(2, 5'd0, 32'h0000_DEAD);
    wait_idle(5);
    step();

    // alu(r9) stalled behind mem(r3).
    issue(0, 5'd3, 32'h0000_0333);
    issue(2, 5'd9, 32'h0000_0999);
    wait_idle(5);
    repeat (2) step();

    // mem and link kept busy so alu must rely on starvation override.
    repeat (30) begin
      if (!rv[0]) issue(0, 5'($urandom_range(1, 31)), $urandom);
      if (!rv[1]) issue(1, 5'd31, $urandom);
      if (!rv[2]) issue(2, 5'($urandom_range(1, 31)), $urandom);
      step();
    end
    wait_idle(20);

    repeat (600) begin
      random_issue(40);
      step();
    end
    wait_idle(40);

    // Reset in RUN with all three requests valid.
    issue(0, 5'd12, 32'h1111_2222);
    issue(1, 5'd31, 32'h3333_4444);
    issue(2, 5'd13, 32'h5555_6666);
    reset = 1;
    step();
    for (int i = 0; i < 3; i++) rv[i] = 0;
    drive();
    reset = 0;
    wait_init(40);

    repeat (100) begin
      random_issue(60);
      step();
    end
    wait_idle(40);
    repeat (2) step();

    @(negedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
